econet_rx_handshake: RTL and testbench
======================================

// Module: econet_rx_handshake
// PURPOSE
// Sequences the Econet four-way receive handshake (scout, ack, data, ack) on the sys_clk side of the
// buffered receiver. Consumes frame_valid/registers of the receiver, drives the transmitter to send
// the two acks, times out a missing data frame, and raises one CPU interrupt per completed transaction.
// PARAMETERS
// SCOUT_LEN    6        byte count (dst2+src2+ctrl+port, FCS excluded) identifying a scout frame
// TMO_WIDTH    20       width of data-frame timeout counter
// DATA_TMO     500000   sys_clk cycles allowed between scout-ack done and data frame valid
// PORTS
// sys_clk        in   1   CPU clock; all logic on rising edge
// reset_n        in   1   asynchronous active-low reset
// enable         in   1   0 = ignore new frames (still acks/discards them); forces IDLE when low in IDLE
// listen_port    in   8   accepted port; 8'h00 = any nonzero port
// frame_valid    in   1   receiver valid-frame flag (level, sys_clk-synchronous)
// frame_len      in   9   receiver byte count of valid frame
// frame_start    in   9   receiver buffer start pointer of valid frame
// frame_ctrl     in   8   control byte (frame byte 4)
// frame_port     in   8   port byte (frame byte 5)
// frame_ack      out  1   1-cycle pulse: frame consumed (drives receiver register select / clear)
// tx_req         out  1   request transmitter to send ack to last scout source
// tx_ready       in   1   transmitter accepts request when tx_req & tx_ready
// tx_done        in   1   1-cycle pulse: ack sent successfully
// tx_fail        in   1   1-cycle pulse: ack not sent (line busy/collision)
// rx_inhibit     out  1   high while an ack is requested or in flight
// irq            out  1   transaction complete or error; level, held until cpu_clear
// cpu_clear      in   1   1-cycle pulse: CPU has processed result; returns to IDLE
// status         out  2   0 none, 1 ok, 2 data timeout, 3 ack tx failure
// rx_ctrl        out  8   control byte latched from scout
// rx_port        out  8   port latched from scout
// data_start     out  9   buffer start pointer of accepted data frame
// data_len       out  9   byte count of accepted data frame
// dropped        out  8   count of frames discarded, saturates at 255, cleared by reset only
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; timeout counter 0; edge register of frame_valid 0.
// - new_frame = frame_valid & ~frame_valid_q (rising edge). Every new_frame produces frame_ack next
//   cycle, in every state; frames not consumed by the FSM increment dropped.
// - States: IDLE, SCOUT_ACK, WAIT_DATA, DATA_ACK, DONE.
// - IDLE: new_frame & enable & frame_len==SCOUT_LEN & frame_port!=0 & (listen_port==0 |
//   frame_port==listen_port) -> latch rx_ctrl/rx_port, -> SCOUT_ACK. Otherwise drop.
// - SCOUT_ACK / DATA_ACK: tx_req=1 and rx_inhibit=1 from state entry; tx_req drops the cycle after
//   tx_req&tx_ready; rx_inhibit holds until tx_done/tx_fail. tx_fail -> DONE, status=3.
//   SCOUT_ACK tx_done -> WAIT_DATA, counter cleared. DATA_ACK tx_done -> DONE, status=1.
// - WAIT_DATA: counter +1 per cycle; new_frame with frame_len>4 -> latch data_start/data_len,
//   -> DATA_ACK. new_frame with frame_len<=4 -> drop, stay. Counter==DATA_TMO-1 -> DONE, status=2.
//   new_frame and timeout same cycle: frame wins.
// - DONE: irq=1. cpu_clear -> IDLE, irq=0, status=0 next cycle; latched fields retain values.
//   cpu_clear outside DONE ignored. Frames in DONE dropped.
// - Frames arriving in SCOUT_ACK/DATA_ACK dropped. tx_done/tx_fail outside ack states ignored.
// - reset_n low mid-transaction: immediate return to reset values; no ack completed.
// - dropped: +1 per dropped frame, holds at 8'hFF.
// TESTING
// 1 Scout len 6 port 0x99, listen 0 -> frame_ack pulse, tx_req until tx_ready, rx_inhibit until tx_done.
// 2 Full handshake: scout, tx_done, data len 40 start 0x030 -> data ack, irq=1 status=1 data_len=40.
// 3 Scout, tx_done, no data for DATA_TMO cycles -> irq=1 status=2 exactly at cycle DATA_TMO.
// 4 Scout port 0x55 with listen 0x99; port 0x00 scout; len 8 frame in IDLE -> each acked, dropped=3.
// 5 tx_fail during DATA_ACK -> status=3 irq=1; cpu_clear -> IDLE status=0; next scout accepted.
// 6 reset_n low in WAIT_DATA -> all outputs 0 same cycle; 300 dropped frames -> dropped=255.

Source files
------------

// File: rtl/econet_rx_handshake.sv
// econet_rx_handshake
//    Runs the receive side of the Econet four-way handshake (scout, ack, data,
//    ack) in the sys_clk domain of the buffered receiver. It consumes the
//    receiver's frame registers, asks the transmitter for the two acks, times
//    out a missing data frame and raises one level interrupt per transaction.
//
//    Ports
//       sys_clk, reset_n           clock, async active-low reset
//       enable, listen_port        accept control (listen_port 0 = any nonzero port)
//       frame_valid/len/start/
//       frame_ctrl/frame_port      receiver frame registers (level valid)
//       frame_ack                  1-cycle pulse, frame consumed
//       tx_req/tx_ready            ack request handshake to transmitter
//       tx_done/tx_fail            ack outcome pulses from transmitter
//       rx_inhibit                 high while an ack is requested or in flight
//       irq, cpu_clear, status     result to CPU (0 none, 1 ok, 2 timeout, 3 tx fail)
//       rx_ctrl, rx_port           fields latched from the scout
//       data_start, data_len       accepted data frame location
//       dropped                    saturating count of discarded frames
//
//    state       | meaning
//    S_IDLE      | waiting for a scout addressed to us
//    S_SCOUT_ACK | scout accepted, sending ack to scout source
//    S_WAIT_DATA | scout acked, timing the wait for the data frame
//    S_DATA_ACK  | data frame accepted, sending final ack
//    S_DONE      | result held for CPU until cpu_clear
module econet_rx_handshake #(
   parameter int SCOUT_LEN = 6,
   parameter int TMO_WIDTH = 20,
   parameter int DATA_TMO  = 500000
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [7:0] listen_port,
   input  logic       frame_valid,
   input  logic [8:0] frame_len,
   input  logic [8:0] frame_start,
   input  logic [7:0] frame_ctrl,
   input  logic [7:0] frame_port,
   output logic       frame_ack,
   output logic       tx_req,
   input  logic       tx_ready,
   input  logic       tx_done,
   input  logic       tx_fail,
   output logic       rx_inhibit,
   output logic       irq,
   input  logic       cpu_clear,
   output logic [1:0] status,
   output logic [7:0] rx_ctrl,
   output logic [7:0] rx_port,
   output logic [8:0] data_start,
   output logic [8:0] data_len,
   output logic [7:0] dropped
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCOUT_ACK,
      S_WAIT_DATA,
      S_DATA_ACK,
      S_DONE
   } state_t;

   localparam logic [8:0]           SCOUT_LEN_V = 9'(SCOUT_LEN);
   localparam logic [TMO_WIDTH-1:0] TMO_LOAD    = TMO_WIDTH'(DATA_TMO - 1);
   localparam logic [TMO_WIDTH-1:0] TMO_ONE     = TMO_WIDTH'(1);

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_OK   = 2'd1;
   localparam logic [1:0] ST_TMO  = 2'd2;
   localparam logic [1:0] ST_FAIL = 2'd3;

   state_t               state;
   logic                 frame_valid_q;
   logic [TMO_WIDTH-1:0] tmo_cnt;

   logic new_frame;
   logic port_match;
   logic scout_hit;
   logic data_hit;
   logic consumed;

   always_comb begin
      new_frame  = frame_valid & ~frame_valid_q;
      port_match = (frame_port != 8'h00) &&
                   ((listen_port == 8'h00) || (frame_port == listen_port));
      scout_hit  = new_frame && enable && (frame_len == SCOUT_LEN_V) && port_match;
      data_hit   = new_frame && (frame_len > 9'd4);
      consumed   = ((state == S_IDLE) && scout_hit) ||
                   ((state == S_WAIT_DATA) && data_hit);
   end

   // Wait-for-data timer counts down from DATA_TMO-1; reaching zero while
   // still waiting is the timeout, so DONE is entered DATA_TMO cycles after
   // the scout ack completes.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         frame_valid_q <= 1'b0;
         tmo_cnt       <= '0;
         frame_ack     <= 1'b0;
         tx_req        <= 1'b0;
         rx_inhibit    <= 1'b0;
         irq           <= 1'b0;
         status        <= ST_NONE;
         rx_ctrl       <= 8'h00;
         rx_port       <= 8'h00;
         data_start    <= 9'h000;
         data_len      <= 9'h000;
         dropped       <= 8'h00;
      end else begin
         frame_valid_q <= frame_valid;
         frame_ack     <= new_frame;

         if (new_frame && !consumed && (dropped != 8'hFF))
            dropped <= dropped + 8'd1;

         case (state)
            S_IDLE: begin
               if (scout_hit) begin
                  rx_ctrl    <= frame_ctrl;
                  rx_port    <= frame_port;
                  tx_req     <= 1'b1;
                  rx_inhibit <= 1'b1;
                  state      <= S_SCOUT_ACK;
               end
            end

            S_SCOUT_ACK, S_DATA_ACK: begin
               if (tx_req && tx_ready)
                  tx_req <= 1'b0;
               // A failure report wins if both outcome pulses ever coincide.
               if (tx_fail) begin
                  tx_req     <= 1'b0;
                  rx_inhibit <= 1'b0;
                  status     <= ST_FAIL;
                  irq        <= 1'b1;
                  state      <= S_DONE;
               end else if (tx_done) begin
                  tx_req     <= 1'b0;
                  rx_inhibit <= 1'b0;
                  if (state == S_SCOUT_ACK) begin
                     tmo_cnt <= TMO_LOAD;
                     state   <= S_WAIT_DATA;
                  end else begin
                     status <= ST_OK;
                     irq    <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_WAIT_DATA: begin
               if (data_hit) begin
                  data_start <= frame_start;
                  data_len   <= frame_len;
                  tx_req     <= 1'b1;
                  rx_inhibit <= 1'b1;
                  state      <= S_DATA_ACK;
               end else if (tmo_cnt == '0) begin
                  status <= ST_TMO;
                  irq    <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_ONE;
               end
            end

            S_DONE: begin
               if (cpu_clear) begin
                  irq    <= 1'b0;
                  status <= ST_NONE;
                  state  <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_econet_rx_handshake.sv
module tb_econet_rx_handshake;

   localparam int TMO = 40;

   logic       sys_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] listen_port = 8'h00;
   logic       frame_valid = 1'b0;
   logic [8:0] frame_len = 9'd0;
   logic [8:0] frame_start = 9'd0;
   logic [7:0] frame_ctrl = 8'h00;
   logic [7:0] frame_port = 8'h00;
   logic       frame_ack;
   logic       tx_req;
   logic       tx_ready = 1'b0;
   logic       tx_done = 1'b0;
   logic       tx_fail = 1'b0;
   logic       rx_inhibit;
   logic       irq;
   logic       cpu_clear = 1'b0;
   logic [1:0] status;
   logic [7:0] rx_ctrl;
   logic [7:0] rx_port;
   logic [8:0] data_start;
   logic [8:0] data_len;
   logic [7:0] dropped;

   int n_vec = 0;
   int n_err = 0;

   econet_rx_handshake #(.SCOUT_LEN(6), .TMO_WIDTH(20), .DATA_TMO(TMO)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .listen_port(listen_port),
      .frame_valid(frame_valid), .frame_len(frame_len), .frame_start(frame_start),
      .frame_ctrl(frame_ctrl), .frame_port(frame_port), .frame_ack(frame_ack),
      .tx_req(tx_req), .tx_ready(tx_ready), .tx_done(tx_done), .tx_fail(tx_fail),
      .rx_inhibit(rx_inhibit), .irq(irq), .cpu_clear(cpu_clear), .status(status),
      .rx_ctrl(rx_ctrl), .rx_port(rx_port), .data_start(data_start), .data_len(data_len),
      .dropped(dropped)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a frame for one edge, then drop frame_valid again.
   task automatic send_frame(input logic [8:0] len, input logic [8:0] start,
                             input logic [7:0] ctrl, input logic [7:0] port);
      frame_len   = len;
      frame_start = start;
      frame_ctrl  = ctrl;
      frame_port  = port;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
   endtask

   task automatic pulse_done();
      tx_done = 1'b1; step(); tx_done = 1'b0;
   endtask

   task automatic pulse_ready();
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      cpu_clear = 1'b1; step(); cpu_clear = 1'b0;
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst_frame_ack", frame_ack, 0);
      chk("rst_tx_req", tx_req, 0);
      chk("rst_irq", irq, 0);
      chk("rst_status", status, 0);
      chk("rst_dropped", dropped, 0);
      reset_n = 1'b1;
      step();

      // 1: scout accepted with listen_port 0
      send_frame(9'd6, 9'h010, 8'h80, 8'h99);
      chk("t1_frame_ack", frame_ack, 1);
      chk("t1_tx_req", tx_req, 1);
      chk("t1_rx_inhibit", rx_inhibit, 1);
      chk("t1_rx_port", rx_port, 8'h99);
      chk("t1_rx_ctrl", rx_ctrl, 8'h80);
      step();
      chk("t1_ack_pulse_end", frame_ack, 0);
      chk("t1_tx_req_held", tx_req, 1);
      pulse_ready();
      chk("t1_tx_req_drop", tx_req, 0);
      chk("t1_inhibit_held", rx_inhibit, 1);
      step();
      chk("t1_inhibit_held2", rx_inhibit, 1);
      pulse_done();
      chk("t1_inhibit_clear", rx_inhibit, 0);
      chk("t1_no_irq", irq, 0);

      // 2: data frame completes the handshake
      send_frame(9'd40, 9'h030, 8'h00, 8'h00);
      chk("t2_frame_ack", frame_ack, 1);
      chk("t2_tx_req", tx_req, 1);
      chk("t2_rx_inhibit", rx_inhibit, 1);
      chk("t2_data_len", data_len, 40);
      chk("t2_data_start", data_start, 9'h030);
      pulse_ready();
      pulse_done();
      chk("t2_irq", irq, 1);
      chk("t2_status", status, 1);
      chk("t2_dropped", dropped, 0);
      pulse_clear();
      chk("t2_irq_clr", irq, 0);
      chk("t2_status_clr", status, 0);
      chk("t2_data_len_kept", data_len, 40);

      // 4: rejected frames in IDLE are acked and counted
      listen_port = 8'h99;
      send_frame(9'd6, 9'h000, 8'h80, 8'h55);
      chk("t4a_frame_ack", frame_ack, 1);
      chk("t4a_tx_req", tx_req, 0);
      chk("t4a_dropped", dropped, 1);
      step();
      listen_port = 8'h00;
      send_frame(9'd6, 9'h000, 8'h80, 8'h00);
      chk("t4b_frame_ack", frame_ack, 1);
      chk("t4b_tx_req", tx_req, 0);
      chk("t4b_dropped", dropped, 2);
      step();
      send_frame(9'd8, 9'h000, 8'h80, 8'h99);
      chk("t4c_frame_ack", frame_ack, 1);
      chk("t4c_tx_req", tx_req, 0);
      chk("t4c_dropped", dropped, 3);
      step();

      // 3: data timeout, short frame ignored while waiting
      send_frame(9'd6, 9'h000, 8'h81, 8'h42);
      chk("t3_tx_req", tx_req, 1);
      pulse_ready();
      pulse_done();
      for (int i = 1; i <= TMO; i++) begin
         frame_valid = (i == 5);
         frame_len   = 9'd4;
         step();
         if (i == 5) chk("t3_short_ack", frame_ack, 1);
         if (i < TMO) chk("t3_irq_wait", irq, 0);
      end
      frame_valid = 1'b0;
      chk("t3_irq", irq, 1);
      chk("t3_status", status, 2);
      chk("t3_dropped", dropped, 4);
      chk("t3_tx_req", tx_req, 0);
      pulse_clear();
      chk("t3_irq_clr", irq, 0);

      // 5: ack failure during data ack
      send_frame(9'd6, 9'h000, 8'h82, 8'h43);
      pulse_ready();
      pulse_done();
      send_frame(9'd20, 9'h100, 8'h00, 8'h00);
      chk("t5_data_start", data_start, 9'h100);
      chk("t5_tx_req", tx_req, 1);
      tx_fail = 1'b1; step(); tx_fail = 1'b0;
      chk("t5_irq", irq, 1);
      chk("t5_status", status, 3);
      chk("t5_tx_req_off", tx_req, 0);
      chk("t5_inhibit_off", rx_inhibit, 0);
      pulse_clear();
      chk("t5_status_clr", status, 0);
      chk("t5_irq_clr", irq, 0);
      send_frame(9'd6, 9'h000, 8'h83, 8'h77);
      chk("t5_next_scout", tx_req, 1);
      chk("t5_next_port", rx_port, 8'h77);

      // 6: asynchronous reset in WAIT_DATA, then dropped saturation
      pulse_ready();
      pulse_done();
      step();
      reset_n = 1'b0;
      #2;
      chk("t6_rx_port", rx_port, 0);
      chk("t6_rx_ctrl", rx_ctrl, 0);
      chk("t6_data_len", data_len, 0);
      chk("t6_data_start", data_start, 0);
      chk("t6_dropped", dropped, 0);
      chk("t6_irq", irq, 0);
      chk("t6_status", status, 0);
      chk("t6_tx_req", tx_req, 0);
      step();
      reset_n = 1'b1;
      enable = 1'b0;
      step();
      for (int i = 1; i <= 300; i++) begin
         send_frame(9'd6, 9'h000, 8'h80, 8'h99);
         if (i == 255) chk("t6_dropped_255", dropped, 255);
         step();
      end
      chk("t6_dropped_sat", dropped, 255);
      chk("t6_disabled_no_req", tx_req, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
